// File: rtl/pentiumx_pkg.sv
// Shared constants and types for the register write-back scoreboard.
//   ADDR_W   : GPR address width
//   NREG     : number of GPRs (2**ADDR_W)
//   CNT_W    : outstanding-write counter width (holds 0..NREG)
//   REG_ZERO : hard-wired zero register
package pentiumx_pkg;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int CNT_W  = 6;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [NREG-1:0]   reg_map_t;
endpackage

// File: rtl/reg_wb_scoreboard_dec.sv
// dec5to32_onehot: combinational address-to-one-hot decoder with enable.
//   en     : when low, onehot is all zeros
//   addr   : register address
//   onehot : one bit set at position addr when enabled
module dec5to32_onehot
  import pentiumx_pkg::*;
(
  input  logic      en,
  input  reg_addr_t addr,
  output reg_map_t  onehot
);
  always_comb begin
    onehot       = '0;
    onehot[addr] = en;
  end
endmodule

// File: rtl/reg_wb_scoreboard.sv
// reg_wb_scoreboard: pending-write scoreboard between ID issue and WB.
// Tracks which GPRs have an outstanding write, stalls ID on RAW/WAW hazards
// against those, and produces the registered one-hot regfile write enable.
// Optional: define WB_BYPASS_EN when the regfile writes in the first half
// cycle and reads in the second, so a source retiring this cycle in WB is
// not a hazard.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   issue_valid/issue_wr/issue_rd : ID instruction and its destination
//   rs/rt/use_rs/use_rt           : source registers and whether read
//   wb_valid/wb_rd                : WB retiring a register write
//   flush                         : squash all in-flight writes
//   stall/issue_ack               : combinational ID handshake
//   wb_we                         : registered one-hot write enable
//   busy/pending_cnt              : pending bitmap and its population
module reg_wb_scoreboard
  import pentiumx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_wr,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic             issue_ack,
  output logic [NREG-1:0]  wb_we,
  output logic [NREG-1:0]  busy,
  output logic [CNT_W-1:0] pending_cnt
);
  logic     hz_rs, hz_rt, hz_wr;
  logic     set_en, clr_en, inc, dec;
  reg_map_t set_mask, clr_mask, we_src, busy_nxt;

`ifdef WB_BYPASS_EN
  // Regfile writes first half-cycle, so a WB-matching source is already valid.
  assign hz_rs = use_rs   & busy[rs]       & (rs != REG_ZERO)       & ~(wb_valid & (wb_rd == rs));
  assign hz_rt = use_rt   & busy[rt]       & (rt != REG_ZERO)       & ~(wb_valid & (wb_rd == rt));
  assign hz_wr = issue_wr & busy[issue_rd] & (issue_rd != REG_ZERO) & ~(wb_valid & (wb_rd == issue_rd));
`else
  assign hz_rs = use_rs   & busy[rs]       & (rs != REG_ZERO);
  assign hz_rt = use_rt   & busy[rt]       & (rt != REG_ZERO);
  assign hz_wr = issue_wr & busy[issue_rd] & (issue_rd != REG_ZERO);
`endif

  assign stall     = issue_valid & ~flush & (hz_rs | hz_rt | hz_wr);
  assign issue_ack = issue_valid & ~stall;

  assign set_en = issue_ack & issue_wr & (issue_rd != REG_ZERO);
  assign clr_en = wb_valid & (wb_rd != REG_ZERO);

  dec5to32_onehot u_dec_set (.en(set_en),   .addr(issue_rd), .onehot(set_mask));
  dec5to32_onehot u_dec_clr (.en(clr_en),   .addr(wb_rd),    .onehot(clr_mask));
  dec5to32_onehot u_dec_we  (.en(wb_valid), .addr(wb_rd),    .onehot(we_src));

  // Clear first, then set: a same-register set/clear leaves the bit set.
  assign busy_nxt = (busy & ~clr_mask) | set_mask;

  // A same-register clear of a busy bit is cancelled by the set, so the
  // count stays put; a clear of a non-busy bit never decrements.
  assign inc = set_en & ~busy[issue_rd];
  assign dec = clr_en & busy[wb_rd] & ~(set_en & (issue_rd == wb_rd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= '0;
      wb_we       <= '0;
      pending_cnt <= '0;
    end else begin
      // An instruction already in WB commits even across a flush.
      wb_we <= we_src & ~reg_map_t'(1);
      if (flush) begin
        busy        <= '0;
        pending_cnt <= '0;
      end else begin
        busy <= busy_nxt & ~reg_map_t'(1);
        if (inc && !dec && pending_cnt != CNT_W'(NREG))
          pending_cnt <= pending_cnt + 1'b1;
        else if (dec && !inc && pending_cnt != '0)
          pending_cnt <= pending_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Directed self-checking bench for reg_wb_scoreboard (either WB_BYPASS_EN build).
module tb_reg_wb_scoreboard;
  import pentiumx_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid, issue_wr, use_rs, use_rt, wb_valid, flush;
  logic [ADDR_W-1:0] issue_rd, rs, rt, wb_rd;
  logic             stall, issue_ack;
  logic [NREG-1:0]  wb_we, busy;
  logic [CNT_W-1:0] pending_cnt;

  int total = 0;
  int bad   = 0;

  reg_wb_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .issue_ack(issue_ack), .wb_we(wb_we),
    .busy(busy), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs may change and outputs settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wr = 0; issue_rd = '0;
    rs = '0; rt = '0; use_rs = 0; use_rt = 0;
    wb_valid = 0; wb_rd = '0; flush = 0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] rd);
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = rd;
  endtask

  initial begin
    rst = 1;
    idle();
    #12;
    check("reset_busy",  busy, 32'h0);
    check("reset_cnt",   32'(pending_cnt), 32'd0);
    check("reset_wb_we", wb_we, 32'h0);
    check("reset_stall", 32'(stall), 32'd0);
    rst = 0;
    step();

    // Issue r8 while WB retires r2 to get nonzero state everywhere.
    issue(5'd8); wb_valid = 1; wb_rd = 5'd2;
    #1 check("first_ack", 32'(issue_ack), 32'd1);
    step();
    check("set8_busy",  busy, 32'h0000_0100);
    check("set8_cnt",   32'(pending_cnt), 32'd1);
    check("wb2_we",     wb_we, 32'h0000_0004);
    idle();
    // Async reset between edges takes effect immediately.
    #2 rst = 1;
    #1;
    check("midrst_busy",  busy, 32'h0);
    check("midrst_cnt",   32'(pending_cnt), 32'd0);
    check("midrst_wb_we", wb_we, 32'h0);
    rst = 0;
    step();

    // RAW hazard on r8.
    issue(5'd8);
    step();
    idle(); issue_valid = 1; rs = 5'd8; use_rs = 1;
    #1 check("raw_stall", 32'(stall), 32'd1);
    check("raw_ack", 32'(issue_ack), 32'd0);
    step();
    check("raw_stall_hold", 32'(stall), 32'd1);
    wb_valid = 1; wb_rd = 5'd8;
    #1;
`ifdef WB_BYPASS_EN
    check("raw_wbcyc_stall", 32'(stall), 32'd0);
    check("raw_wbcyc_ack",   32'(issue_ack), 32'd1);
`else
    check("raw_wbcyc_stall", 32'(stall), 32'd1);
    check("raw_wbcyc_ack",   32'(issue_ack), 32'd0);
`endif
    step();
    check("raw_wb_we",   wb_we, 32'h0000_0100);
    check("raw_busy",    busy, 32'h0);
    wb_valid = 0;
    #1 check("raw_after_stall", 32'(stall), 32'd0);
    check("raw_after_ack", 32'(issue_ack), 32'd1);
    step();
    check("raw_cnt", 32'(pending_cnt), 32'd0);

    // r0 immunity.
    issue(5'd0); rs = 5'd0; use_rs = 1;
    #1 check("r0_stall", 32'(stall), 32'd0);
    step();
    check("r0_busy", busy, 32'h0);
    check("r0_cnt",  32'(pending_cnt), 32'd0);
    idle(); issue_valid = 1; rs = 5'd0; use_rs = 1; wb_valid = 1; wb_rd = 5'd0;
    #1 check("r0_src_stall", 32'(stall), 32'd0);
    step();
    check("r0_wb_we", wb_we, 32'h0);

    // Simultaneous set/clear on r5.
    issue(5'd5);
    step();
    check("r5_busy", busy, 32'h0000_0020);
    issue(5'd5); wb_valid = 1; wb_rd = 5'd5;
    #1;
`ifdef WB_BYPASS_EN
    check("simul_stall", 32'(stall), 32'd0);
    step();
    check("simul_busy", busy, 32'h0000_0020);
    check("simul_cnt",  32'(pending_cnt), 32'd1);
`else
    check("simul_stall", 32'(stall), 32'd1);
    step();
    check("simul_busy", busy, 32'h0);
    check("simul_cnt",  32'(pending_cnt), 32'd0);
`endif
    check("simul_wb_we", wb_we, 32'h0000_0020);

    // Flush alone empties state.
    idle(); flush = 1;
    step();
    check("flush0_busy", busy, 32'h0);
    check("flush0_cnt",  32'(pending_cnt), 32'd0);

    // Build r3, r9, r31 then flush with concurrent issue r4 and WB r9.
    issue(5'd3);  step();
    issue(5'd9);  step();
    issue(5'd31); step();
    check("pre_flush_busy", busy, 32'h8000_0208);
    check("pre_flush_cnt",  32'(pending_cnt), 32'd3);
    issue(5'd4); rs = 5'd3; use_rs = 1; wb_valid = 1; wb_rd = 5'd9; flush = 1;
    #1 check("flush_stall", 32'(stall), 32'd0);
    step();
    check("flush_busy",  busy, 32'h0);
    check("flush_cnt",   32'(pending_cnt), 32'd0);
    check("flush_wb_we", wb_we, 32'h0000_0200);

    // Counter full range.
    for (int r = 1; r < NREG; r++) begin
      issue(5'(r));
      step();
    end
    check("full_cnt",  32'(pending_cnt), 32'd31);
    check("full_busy", busy, 32'hFFFF_FFFE);
    issue(5'd3);
    #1 check("waw_stall", 32'(stall), 32'd1);
    idle(); wb_valid = 1; wb_rd = 5'd7;
    step();
    check("wb7_cnt",  32'(pending_cnt), 32'd30);
    check("wb7_busy", busy, 32'hFFFF_FF7E);
    step();
    check("wb7_again_cnt", 32'(pending_cnt), 32'd30);
    check("wb7_again_we",  wb_we, 32'h0000_0080);
    idle(); step();
    check("idle_wb_we", wb_we, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_wb_scoreboard.md
Name: reg_wb_scoreboard

Overview:
- Write-back side of the register-destination path. The destination-select mux picks a 5-bit rd upstream; this block decodes rd back into per-register state.
- Tracks which of the 32 GPRs have a pending write and raises a stall when an issuing instruction reads a pending register.
- Produces the registered one-hot register-file write-enable at write-back.
- Sits between ID (issue) and WB in the 5-stage MIPS pipeline.

Parameters:
- ADDR_W, 5, register address width.
- NREG, 32, number of GPRs (must equal 2**ADDR_W).
- CNT_W, 6, width of the outstanding-write counter (holds 0..NREG).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  ID stage presents an instruction.
- issue_wr  in  1  instruction writes a GPR.
- issue_rd  in  ADDR_W  destination register.
- rs  in  ADDR_W  source register 1.
- rt  in  ADDR_W  source register 2.
- use_rs  in  1  rs is actually read.
- use_rt  in  1  rt is actually read.
- wb_valid  in  1  WB stage retires a register write.
- wb_rd  in  ADDR_W  register being written back.
- flush  in  1  squash all in-flight writes (branch/exception).
- stall  out  1  ID must hold; combinational.
- issue_ack  out  1  issue_valid & ~stall; combinational.
- wb_we  out  NREG  registered one-hot regfile write enable.
- busy  out  NREG  pending-write bitmap (registered).
- pending_cnt  out  CNT_W  number of set busy bits (registered).

Behaviour:
- Reset (async, rst=1): busy=0, wb_we=0, pending_cnt=0. stall then evaluates to 0.
- Register 0 is never busy. Issue or WB to r0 is ignored by busy/count. wb_we[0] is always 0.
- Hazard terms:
  - hz_rs = use_rs & busy[rs] & (rs!=0)
  - hz_rt = use_rt & busy[rt] & (rt!=0)
  - hz_wr = issue_wr & busy[issue_rd] & (issue_rd!=0), a WAW hazard. Only one write per register may be outstanding.
  - stall = issue_valid & ~flush & (hz_rs | hz_rt | hz_wr).
- Set event: issue_ack & issue_wr & issue_rd!=0 sets busy[issue_rd] at the next edge.
- Clear event: wb_valid & wb_rd!=0 clears busy[wb_rd] at the next edge.
- Simultaneous set and clear to the same register: set wins (clear first, then set), and the counter is unchanged. WAW stall makes this occur only when a WB retires the same register in the same cycle; with the bypass feature off it cannot occur.
- pending_cnt: +1 on set of a non-busy bit, -1 on clear of a busy bit, net on both. It never wraps; it saturates at 0 and NREG. A clear of a non-busy bit is ignored, with no decrement.
- wb_we: wb_we <= wb_valid ? onehot(wb_rd) & ~1 : 0. One-cycle latency from WB. Unaffected by flush, because an instruction already in WB commits.
- flush: at the next edge busy<=0 and pending_cnt<=0. It overrides set and clear in the same cycle, and forces stall=0 that cycle. wb_we behaves normally.
- No internal FSM beyond the busy bitmap. All state updates happen on the rising edge of clk.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a source matching wb_rd while wb_valid is not a hazard that cycle, because the register file writes first half and reads second half. Concretely, hz_rs and hz_rt each exclude (wb_valid & wb_rd==src). hz_wr also excludes wb_rd==issue_rd.
- Undefined: no exclusion; the stall persists through the WB cycle and releases the cycle after.

Decomposition:
- Package pentiumx_pkg holds: ADDR_W, NREG, CNT_W constants; REG_ZERO=5'd0; typedef for the reg address and for the NREG bitmap.
- One sub-module, dec5to32_onehot: combinational 5-to-32 decoder with enable. It is instantiated three times: for the issue set mask, the WB clear mask, and the wb_we source.

Test Plan:
- Reset mid-operation: busy=0x0000_0100, assert rst asynchronously between edges -> busy=0, pending_cnt=0, wb_we=0 immediately.
- RAW hazard: issue rd=8; next cycle issue rs=8 use_rs=1 -> stall=1 and issue_ack=0 until wb_valid wb_rd=8. Without the macro, stall drops the cycle after WB; with WB_BYPASS_EN, stall drops in the WB cycle.
- r0 immunity: issue rd=0, then rs=0 -> busy stays 0, stall=0, pending_cnt=0; wb_valid wb_rd=0 -> wb_we=0.
- Simultaneous set/clear: busy[5]=1, same cycle WB rd=5 and accepted issue rd=5 (bypass on) -> busy[5]=1, pending_cnt unchanged.
- Flush: busy has r3, r9, r31 set, pending_cnt=3; flush=1 while issue rd=4 and wb rd=9 -> busy=0, pending_cnt=0, wb_we=0x0000_0200 next cycle.
- Counter full range: issue r1..r31 back to back -> pending_cnt=31; a WB of a non-busy register is ignored.
